// File: rtl/jk_bank_driver.sv
// jk_bank_driver: excitation-side driver for a bank of WIDTH external JK flip-flops.
// Target words arrive on a valid/ready port and are queued in a DEPTH-entry FIFO.
// For each target the block drives the minimal J/K pattern for one clock.
// The J/K pattern moves the bank from its current value to the target.
// Optional feature macro: JK_BANK_VERIFY_EN.
//   When defined, a CHECK state compares q_fb against the applied target.
//   Any mismatch sets the sticky err output.
//   When undefined, targets chain back to back using the shadow register as base.
module jk_bank_driver #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done
`ifdef JK_BANK_VERIFY_EN
  ,
  output logic             err
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

`ifdef JK_BANK_VERIFY_EN
  typedef enum logic [1:0] {StIdle, StDrive, StCheck} state_e;
`else
  typedef enum logic [0:0] {StIdle, StDrive} state_e;
`endif

  // ---------------------------------------------------------------------------
  // Command FIFO: pointers carry an extra wrap bit so full and empty are distinct.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             full, empty;
  logic             push, pop;
  logic [WIDTH-1:0] head;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign cmd_ready = !full;
  // A pop in the same cycle does not open a slot for a push while full.
  assign push      = cmd_valid && !full;
  assign head      = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer next-state: advance on accepted push / FSM pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // Pointer registers; a reset discards every queued target.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= cmd_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  state_e           state_q;
  logic [WIDTH-1:0] j_q, k_q;
  logic [WIDTH-1:0] shadow_q;
  logic             done_q;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] j_load, k_load;
`ifdef JK_BANK_VERIFY_EN
  logic             err_q;
`endif

  // Decide whether the head target is loaded at this edge.
  always_comb begin
    pop = 1'b0;
    case (state_q)
      StIdle:  pop = !empty;
`ifdef JK_BANK_VERIFY_EN
      StDrive: pop = 1'b0;
      StCheck: pop = !empty;
`else
      StDrive: pop = !empty;
`endif
      default: pop = 1'b0;
    endcase
  end

  // Base value: q_fb is settled except when chaining straight out of DRIVE.
  always_comb begin
    base = q_fb;
`ifndef JK_BANK_VERIFY_EN
    if (state_q == StDrive) begin
      base = shadow_q;
    end
`endif
  end

  // Minimal excitation: set bits that must rise, reset bits that must fall, hold the rest.
  assign j_load = head & ~base;
  assign k_load = ~head & base;

  // FSM with registered J/K, done and err; J/K default to hold (0) every cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      j_q      <= '0;
      k_q      <= '0;
      shadow_q <= '0;
      done_q   <= 1'b0;
`ifdef JK_BANK_VERIFY_EN
      err_q    <= 1'b0;
`endif
    end else begin
      j_q    <= '0;
      k_q    <= '0;
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          state_q <= StIdle;
        end
`ifdef JK_BANK_VERIFY_EN
        StDrive: begin
          state_q <= StCheck;
        end
        StCheck: begin
          done_q  <= 1'b1;
          state_q <= StIdle;
          if (q_fb != shadow_q) begin
            err_q <= 1'b1;
          end
        end
`else
        StDrive: begin
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
`endif
        default: begin
          state_q <= StIdle;
        end
      endcase
      // Loading the next target overrides the fall-back to IDLE.
      if (pop) begin
        j_q      <= j_load;
        k_q      <= k_load;
        shadow_q <= head;
        state_q  <= StDrive;
      end
    end
  end

  assign j    = j_q;
  assign k    = k_q;
  assign done = done_q;
  assign busy = !empty || (state_q != StIdle);
`ifdef JK_BANK_VERIFY_EN
  assign err  = err_q;
`endif

endmodule

// File: tb/tb_jk_bank_driver.sv
// Self-checking bench for jk_bank_driver (works with and without JK_BANK_VERIFY_EN).
module tb_jk_bank_driver;

  localparam int W = 4;
  localparam int D = 4;
`ifdef JK_BANK_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cmd_valid = 1'b0;
  logic [W-1:0] cmd_data = '0;
  logic         cmd_ready;
  logic [W-1:0] q_fb, j, k;
  logic         busy, done;
`ifdef JK_BANK_VERIFY_EN
  logic         err;
`endif

  always #5 clk = ~clk;

  jk_bank_driver #(
    .WIDTH (W),
    .DEPTH (D)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .q_fb      (q_fb),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .done      (done)
`ifdef JK_BANK_VERIFY_EN
    ,
    .err       (err)
`endif
  );

  // External JK bank: Q+ = J&~Q | ~K&Q, with optional stuck-at-0 bits.
  logic [W-1:0] bank  = '0;
  logic [W-1:0] stuck = '0;
  always @(posedge clk) bank <= ((j & ~bank) | (~k & bank)) & ~stuck;
  assign q_fb = bank & ~stuck;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // Reference model: targets in acceptance order, plus what was on j/k/q_fb
  // one and two cycles before each done pulse.
  logic [W-1:0] exp_q[$];
  logic         err_exp = 1'b0;
  logic         last_acc;
  logic [W-1:0] hj1 = '0, hk1 = '0, hb1 = '0, hj2 = '0, hk2 = '0, hb2 = '0;

  task automatic cycle();
    logic         acc;
    logic [W-1:0] t, b, jj, kk;
    acc = reset && cmd_valid && cmd_ready;
    hj2 = hj1; hk2 = hk1; hb2 = hb1;
    hj1 = j;   hk1 = k;   hb1 = q_fb;
    @(negedge clk);
    last_acc = acc;
    if (!reset) begin
      exp_q.delete();
      err_exp = 1'b0;
    end else if (acc) begin
      exp_q.push_back(cmd_data);
    end
    chk("jk_excl", j & k, '0);
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk1("done_spurious", done, 1'b0);
      end else begin
        t = exp_q.pop_front();
        if (VER) begin
          jj = hj2; kk = hk2; b = hb2;
        end else begin
          jj = hj1; kk = hk1; b = hb1;
        end
        chk("j_drive", jj, t & ~b);
        chk("k_drive", kk, ~t & b);
        chk("bank_val", q_fb, t & ~stuck);
`ifdef JK_BANK_VERIFY_EN
        if ((t & stuck) != '0) err_exp = 1'b1;
        chk1("err_flag", err, err_exp);
`endif
      end
    end
  endtask

  task automatic drain();
    cmd_valid = 1'b0;
    for (int n = 0; n < 100 && (exp_q.size() != 0 || busy); n++) cycle();
    chk1("drain_busy", busy, 1'b0);
    chk1("drain_empty", exp_q.size() == 0, 1'b1);
  endtask

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic [W-1:0] ej;
    logic [W-1:0] ek;
    logic         ed;
    logic         eb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [W-1:0] d, logic [W-1:0] ej, logic [W-1:0] ek,
                              logic ed, logic eb);
    vec_t r;
    r.v = v; r.d = d; r.ej = ej; r.ek = ek; r.ed = ed; r.eb = eb;
    return r;
  endfunction

  initial begin
    int  n;
    logic saw_low;

    // Reset
    reset = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
    chk("rst_j", j, '0);
    chk("rst_k", k, '0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ready", cmd_ready, 1'b1);
`ifdef JK_BANK_VERIFY_EN
    chk1("rst_err", err, 1'b0);
`endif

    // Cycle-exact vectors from a bank at 0000
`ifdef JK_BANK_VERIFY_EN
    tbl.push_back(mk(1'b1, 4'b1010, 4'b0000, 4'b0000, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b1010, 4'b0000, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 4'b0110, 4'b0000, 4'b0000, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0100, 4'b1000, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 4'b0110, 4'b0000, 4'b0000, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0));
`else
    tbl.push_back(mk(1'b1, 4'b1010, 4'b0000, 4'b0000, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b1010, 4'b0000, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 4'b0110, 4'b0000, 4'b0000, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0100, 4'b1000, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 4'b0110, 4'b0000, 4'b0000, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0110, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 4'b0011, 4'b0000, 4'b0000, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 4'b1100, 4'b0011, 4'b0000, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 4'b1111, 4'b1100, 4'b0011, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0011, 4'b0000, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));
`endif
    for (int i = 0; i < tbl.size(); i++) begin
      cmd_valid = tbl[i].v;
      cmd_data  = tbl[i].d;
      cycle();
      chk($sformatf("vec%0d_j", i), j, tbl[i].ej);
      chk($sformatf("vec%0d_k", i), k, tbl[i].ek);
      chk1($sformatf("vec%0d_done", i), done, tbl[i].ed);
      chk1($sformatf("vec%0d_busy", i), busy, tbl[i].eb);
      chk1($sformatf("vec%0d_ready", i), cmd_ready, 1'b1);
    end
    drain();
    if (!VER) chk("chain_final_bank", q_fb, 4'b1111);

    // Burst of 2*DEPTH+2 back-to-back pushes; ready may only drop when the FIFO can fill
    saw_low = 1'b0;
    for (int i = 0; i < 2 * D + 2; i++) begin
      cmd_valid = 1'b1;
      cmd_data  = W'($urandom);
      n = 0;
      do begin
        if (!cmd_ready) saw_low = 1'b1;
        cycle();
        n++;
      end while (!last_acc && n < 50);
      chk1("burst_accept", last_acc, 1'b1);
    end
    drain();
    chk1("burst_ready_low_seen", saw_low, VER);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      cmd_valid = ($urandom_range(0, 9) < 6);
      cmd_data  = W'($urandom);
      cycle();
    end
    drain();

`ifdef JK_BANK_VERIFY_EN
    // Stuck bit0: err must set after CHECK and stay set through good targets
    stuck = 4'b0001;
    cmd_valid = 1'b1; cmd_data = 4'b0001;
    cycle();
    drain();
    chk1("stuck_err_set", err, 1'b1);
    cmd_valid = 1'b1; cmd_data = 4'b0010;
    cycle();
    cmd_data = 4'b0100;
    cycle();
    drain();
    chk1("stuck_err_sticky", err, 1'b1);
    stuck = '0;
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    chk1("err_cleared_by_reset", err, 1'b0);
`endif

    // Reset while in DRIVE with targets queued
    cmd_valid = 1'b1; cmd_data = 4'b0101;
    cycle();
    cmd_data = 4'b1010;
    cycle();
`ifdef JK_BANK_VERIFY_EN
    cmd_data = 4'b0011;
    cycle();
    cmd_data = 4'b1100;
    cycle();
`endif
    chk1("pre_abort_busy", busy, 1'b1);
    cmd_valid = 1'b0;
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    chk("abort_j", j, '0);
    chk("abort_k", k, '0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_done", done, 1'b0);
    chk1("abort_ready", cmd_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk1("post_abort_idle", busy, 1'b0);
      chk1("post_abort_nodone", done, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
